dht22_top: RTL and testbench
============================

Name: dht22_top

Overview:
- Single-wire host controller for a DHT22 humidity/temperature sensor.
- On a start request it runs the DHT22 start/response handshake over an open-drain bidirectional line, then receives 40 data bits and checks parity.
- On a good frame it converts humidity and temperature (tenths units) to 3-digit BCD plus a temperature sign flag, and pulses data_ready.
- Sits between system control logic and the sensor pin; the line has an external pull-up.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz. All protocol times derive from it: US_TICKS = CLK_FREQ/1_000_000 cycles per µs.

Ports:
- clk  in  1  system clock.
- arstn  in  1  reset, synchronous, active-low.
- start_read  in  1  one-cycle request to start a read; ignored unless idle.
- data_ready  out  1  one-cycle pulse when new valid data is on the outputs.
- sys_idle  out  1  high when idle and ready to accept start_read.
- humidity_bcd  out  12  [3:0]=tenths, [7:4]=units, [11:8]=tens of RH%.
- negativo_temp  out  1  temperature sign, equal to bit 15 of the received temperature word.
- temperature_bcd  out  12  [3:0]=tenths, [7:4]=units, [11:8]=tens of °C magnitude.
- dht22_in_out  inout  1  sensor line. Driven 0 or released to 'z', never driven 1.

Behaviour:
- Reset (arstn=0 at a clk edge) values:
  - State IDLE; line released.
  - data_ready=0, sys_idle=1.
  - Both BCD outputs 0; negativo_temp=0.
  - Bit counter and shift register cleared.
- Input sampling: line read through a 2-flop synchronizer; all edge detection uses the synchronized value.
- State machine:
  - IDLE: sys_idle=1. start_read=1 → START_LOW; sys_idle drops the next cycle. start_read in any other state is ignored.
  - START_LOW: drive line 0 for 1000 µs, then release → WAIT_RESP.
  - WAIT_RESP: wait for line low (sensor response), timeout 200 µs → RESP_LOW.
  - RESP_LOW: wait for line high, timeout 200 µs → RESP_HIGH.
  - RESP_HIGH: wait for line low, timeout 200 µs → BIT_LOW.
  - BIT_LOW: wait for line high, timeout 200 µs → BIT_HIGH; high-time counter reset.
  - BIT_HIGH: count high time. On line low:
    - bit = 1 if high time ≥ 48 µs, else 0; shift bit in MSB first.
    - After 40 bits → CHECK, else → BIT_LOW.
    - Timeout 200 µs high → abort.
  - CHECK: frame bytes B0..B4 in received order (hum[15:8], hum[7:0], tmp[15:8], tmp[7:0], parity).
    - Pass if (B0+B1+B2+B3) mod 256 == B4 → CONVERT; else abort.
  - CONVERT: binary→BCD on humidity[15:0] and temperature[14:0], by repeated subtraction or double-dabble (multi-cycle allowed).
    - Digits = value mod 10, (value/10) mod 10, (value/100) mod 10.
    - Values ≥1000 keep only the low three decimal digits.
    - Load humidity_bcd, temperature_bcd and negativo_temp → DONE.
  - DONE: pulse data_ready for exactly one cycle, at least one cycle after the outputs were updated, and wait for the line to be high. Next cycle → IDLE with sys_idle=1.
- Abort (any timeout or parity fail):
  - Release the line and return to IDLE; sys_idle rises again.
  - No data_ready pulse; outputs keep their previous values.
- The line is driven only in START_LOW; in every other state it is 'z'.
- A reset mid-transaction immediately releases the line and restores the reset values.
- Timeouts are measured from state entry; the counter is wide enough for 1000 µs at CLK_FREQ.

Test Plan:
- Reset, then a sensor model sends hum=0x01F3 (499), tmp=0x00FA (250), correct parity → humidity_bcd=0x499, temperature_bcd=0x250, negativo_temp=0, data_ready one-cycle pulse, sys_idle low during the read then high.
- Frame with tmp=0x8385 (sign set, magnitude 901) and hum=999 → temperature_bcd=0x901, negativo_temp=1, humidity_bcd=0x999.
- Parity byte corrupted by +1 → no data_ready; outputs hold the previous frame's values; sys_idle returns to 1.
- No sensor response after start pulse → timeout ~200 µs after release, return to IDLE, no data_ready; a following good read (hum=0, tmp=0) → all BCD 0, data_ready pulse.
- start_read pulsed repeatedly while busy → ignored, exactly one transaction; 5 random frames back-to-back with 2 ms gaps all decode correctly.
- arstn asserted during bit reception → line released, sys_idle=1, outputs 0; next start_read completes a normal read.

Source files
------------

// File: rtl/dht22_top.sv
// DHT22 single-wire host: start handshake, 40-bit capture with parity check,
// and binary-to-BCD conversion of humidity and temperature magnitude.
module dht22_top #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        start_read,
  output logic        data_ready,
  output logic        sys_idle,
  output logic [11:0] humidity_bcd,
  output logic        negativo_temp,
  output logic [11:0] temperature_bcd,
  inout  wire         dht22_in_out
);

  localparam int US_TICKS = CLK_FREQ / 1_000_000;
  localparam int TW       = $clog2(1000 * US_TICKS + 1) + 1;

  localparam logic [TW-1:0] T_START = TW'(1000 * US_TICKS);
  localparam logic [TW-1:0] T_OUT   = TW'(200 * US_TICKS);
  localparam logic [TW-1:0] T_ONE   = TW'(48 * US_TICKS);

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    CONVERT,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [4:0]    conv_cnt;
  logic [15:0]   hum_sh;
  logic [15:0]   tmp_sh;
  logic [19:0]   hum_acc;
  logic [19:0]   tmp_acc;
  logic          temp_sign;
  logic          pulsed;
  logic          drive_low;

  logic sync1, sync2, line_prev;
  logic rise, fall;
  logic [7:0] frame_sum;

  assign dht22_in_out = drive_low ? 1'b0 : 1'bz;

  // Idle level of the pulled-up line is 1, so reset the synchronizer high.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= dht22_in_out;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  assign rise      = sync2 & ~line_prev;
  assign fall      = ~sync2 & line_prev;
  assign frame_sum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
  function automatic logic [19:0] dabble(input logic [19:0] bcd, input logic b);
    logic [19:0] adj;
    adj = bcd;
    for (int d = 0; d < 5; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    return {adj[18:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state           <= IDLE;
      timer           <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      conv_cnt        <= '0;
      hum_sh          <= '0;
      tmp_sh          <= '0;
      hum_acc         <= '0;
      tmp_acc         <= '0;
      temp_sign       <= 1'b0;
      pulsed          <= 1'b0;
      drive_low       <= 1'b0;
      data_ready      <= 1'b0;
      sys_idle        <= 1'b1;
      humidity_bcd    <= '0;
      temperature_bcd <= '0;
      negativo_temp   <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      timer      <= timer + TW'(1);
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (start_read) begin
            state     <= START_LOW;
            drive_low <= 1'b1;
            sys_idle  <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
          end
        end
        START_LOW: begin
          if (timer == T_START - TW'(1)) begin
            drive_low <= 1'b0;
            state     <= WAIT_RESP;
            timer     <= '0;
          end
        end
        WAIT_RESP: begin
          if (fall) begin
            state <= RESP_LOW;
            timer <= '0;
          end else if (timer >= T_OUT) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        RESP_LOW: begin
          if (rise) begin
            state <= RESP_HIGH;
            timer <= '0;
          end else if (timer >= T_OUT) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        RESP_HIGH: begin
          if (fall) begin
            state <= BIT_LOW;
            timer <= '0;
          end else if (timer >= T_OUT) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        BIT_LOW: begin
          if (rise) begin
            state <= BIT_HIGH;
            timer <= '0;
          end else if (timer >= T_OUT) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        // The state timer doubles as the high-time counter for each bit.
        BIT_HIGH: begin
          if (fall) begin
            shreg   <= {shreg[38:0], (timer >= T_ONE)};
            bit_cnt <= bit_cnt + 6'd1;
            timer   <= '0;
            state   <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
          end else if (timer >= T_OUT) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        CHECK: begin
          if (frame_sum == shreg[7:0]) begin
            hum_sh    <= shreg[39:24];
            tmp_sh    <= {1'b0, shreg[22:8]};
            temp_sign <= shreg[23];
            hum_acc   <= '0;
            tmp_acc   <= '0;
            conv_cnt  <= '0;
            state     <= CONVERT;
          end else begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_cnt == 5'd16) begin
            humidity_bcd    <= hum_acc[11:0];
            temperature_bcd <= tmp_acc[11:0];
            negativo_temp   <= temp_sign;
            pulsed          <= 1'b0;
            state           <= DONE;
          end else begin
            hum_acc  <= dabble(hum_acc, hum_sh[15]);
            tmp_acc  <= dabble(tmp_acc, tmp_sh[15]);
            hum_sh   <= {hum_sh[14:0], 1'b0};
            tmp_sh   <= {tmp_sh[14:0], 1'b0};
            conv_cnt <= conv_cnt + 5'd1;
          end
        end
        // Pulse first, then hold here until the sensor releases the line.
        DONE: begin
          if (!pulsed) begin
            data_ready <= 1'b1;
            pulsed     <= 1'b1;
          end else if (sync2) begin
            state    <= IDLE;
            sys_idle <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          drive_low <= 1'b0;
          sys_idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_top.sv
// Self-checking bench for dht22_top: behavioural DHT22 sensor on a pulled-up
// line, scoreboard of expected conversions popped on each data_ready pulse.
`timescale 1ns/1ps
module tb_dht22_top;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        start_read = 1'b0;
  logic        data_ready;
  logic        sys_idle;
  logic [11:0] humidity_bcd;
  logic        negativo_temp;
  logic [11:0] temperature_bcd;
  wire         line;
  logic        sens_low = 1'b0;

  assign line = sens_low ? 1'b0 : 1'bz;
  pullup (line);

  dht22_top #(.CLK_FREQ(1_000_000)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .start_read      (start_read),
    .data_ready      (data_ready),
    .sys_idle        (sys_idle),
    .humidity_bcd    (humidity_bcd),
    .negativo_temp   (negativo_temp),
    .temperature_bcd (temperature_bcd),
    .dht22_in_out    (line)
  );

  always #500 clk = ~clk;

  typedef struct {
    logic [11:0] h;
    logic [11:0] t;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dr_count = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] parity8(input logic [15:0] h, input logic [15:0] t);
    return 8'(h[15:8] + h[7:0] + t[15:8] + t[7:0]);
  endfunction

  task automatic wait_us(input int n);
    #(n * 1000);
  endtask

  task automatic push_expected(input logic [15:0] h, input logic [15:0] t);
    exp_t e;
    e.h = to_bcd(int'(h));
    e.t = to_bcd(int'(t[14:0]));
    e.n = t[15];
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_read = 1'b1;
    @(negedge clk) start_read = 1'b0;
  endtask

  // Sensor side: observe host start pulse, then respond with nbits data bits.
  task automatic send_frame(input logic [15:0] hum, input logic [15:0] tmp,
                            input logic [7:0] par, input int nbits);
    logic [39:0] frame;
    int n;
    frame = {hum, tmp, par};
    n = 0;
    while (line !== 1'b0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (line !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_low_seen: line=%b required 0", line);
      return;
    end
    n = 0;
    while (line === 1'b0 && n < 1500) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n < 998 || n > 1002) begin
      miscompares++;
      $display("[TB] FAIL start_pulse_len: %0d cycles, required 1000", n);
      return;
    end
    if (nbits == 0) return;
    #298;
    wait_us(20);
    sens_low = 1'b1; wait_us(80);
    sens_low = 1'b0; wait_us(80);
    for (int i = 0; i < nbits; i++) begin
      sens_low = 1'b1; wait_us(20);
      sens_low = 1'b0; wait_us(frame[39-i] ? 70 : 26);
    end
    sens_low = 1'b1; wait_us(20);
    sens_low = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] hum, input logic [15:0] tmp,
                         input logic [7:0] par, input bit good, input bit spam);
    int dr0;
    int n;
    dr0 = dr_count;
    if (good) push_expected(hum, tmp);
    pulse_start();
    vectors++;
    if (sys_idle !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_idle: sys_idle=%b required 0", sys_idle);
    end
    fork
      send_frame(hum, tmp, par, 40);
      if (spam) begin
        for (int k = 0; k < 20; k++) begin
          repeat (37) @(negedge clk);
          start_read = 1'b1;
          @(negedge clk) start_read = 1'b0;
        end
      end
    join
    n = 0;
    while (sys_idle !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    vectors++;
    if (sys_idle !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL idle_return: sys_idle=%b required 1", sys_idle);
    end
    vectors++;
    if (dr_count - dr0 !== (good ? 1 : 0)) begin
      miscompares++;
      $display("[TB] FAIL ready_pulses: %0d pulses, required %0d", dr_count - dr0, good ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sys_idle !== 1'b1 || data_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: idle=%b ready=%b required 1 0", sys_idle, data_ready);
    end
    vectors++;
    if (humidity_bcd !== 12'h000 || temperature_bcd !== 12'h000 || negativo_temp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: h=%h t=%h n=%b required 000 000 0",
               humidity_bcd, temperature_bcd, negativo_temp);
    end
    vectors++;
    if (line !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_line: line=%b required 1", line);
    end
    arstn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    do_read(16'h01F3, 16'h00FA, parity8(16'h01F3, 16'h00FA), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_negative();
    do_read(16'd999, 16'h8385, parity8(16'd999, 16'h8385), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    do_read(16'hFFFF, 16'hFFFF, parity8(16'hFFFF, 16'hFFFF), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    do_read(16'd999, 16'h8385, parity8(16'd999, 16'h8385), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_parity_error();
    do_read(16'h0123, 16'h0045, parity8(16'h0123, 16'h0045) + 8'd1, 1'b0, 1'b0);
    vectors++;
    if (humidity_bcd !== 12'h999 || temperature_bcd !== 12'h901 || negativo_temp !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_hold: h=%h t=%h n=%b required 999 901 1",
               humidity_bcd, temperature_bcd, negativo_temp);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_no_response();
    int n;
    int dr0;
    dr0 = dr_count;
    pulse_start();
    send_frame(16'h0, 16'h0, 8'h0, 0);
    n = 0;
    while (sys_idle !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n < 195 || n > 210) begin
      miscompares++;
      $display("[TB] FAIL resp_timeout: %0d cycles after release, required about 200", n);
    end
    @(negedge clk);
    vectors++;
    if (dr_count !== dr0 || humidity_bcd !== 12'h999 || temperature_bcd !== 12'h901) begin
      miscompares++;
      $display("[TB] FAIL timeout_hold: pulses=%0d h=%h t=%h required 0 999 901",
               dr_count - dr0, humidity_bcd, temperature_bcd);
    end
    repeat (20) @(negedge clk);
    do_read(16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] h;
    logic [15:0] t;
    int n;
    do_read(16'd655, 16'h0123, parity8(16'd655, 16'h0123), 1'b1, 1'b1);
    n = 0;
    repeat (2000) begin
      @(negedge clk);
      if (line !== 1'b1 || sys_idle !== 1'b1) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("[TB] FAIL spam_extra_txn: %0d busy cycles after read, required 0", n);
    end
    for (int i = 0; i < 5; i++) begin
      h = 16'($urandom_range(0, 65535));
      t = 16'($urandom_range(0, 65535));
      do_read(h, t, parity8(h, t), 1'b1, 1'b0);
      repeat (2000) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    repeat (100) @(negedge clk);
    vectors++;
    if (line !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_drive: line=%b required 0", line);
    end
    arstn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (line !== 1'b1 || sys_idle !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release: line=%b idle=%b required 1 1", line, sys_idle);
    end
    arstn = 1'b1;
    repeat (300) @(negedge clk);
    pulse_start();
    fork
      send_frame(16'h0246, 16'h0135, parity8(16'h0246, 16'h0135), 40);
      begin
        repeat (1500) @(negedge clk);
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (sys_idle !== 1'b1 || humidity_bcd !== 12'h000 ||
            temperature_bcd !== 12'h000 || negativo_temp !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_mid: idle=%b h=%h t=%h n=%b required 1 000 000 0",
                   sys_idle, humidity_bcd, temperature_bcd, negativo_temp);
        end
        arstn = 1'b1;
      end
    join
    repeat (300) @(negedge clk);
    do_read(16'd875, 16'h8064, parity8(16'd875, 16'h8064), 1'b1, 1'b0);
  endtask

  initial begin
    fork
      begin : monitor
        logic prev_dr;
        exp_t e;
        prev_dr = 1'b0;
        forever begin
          @(negedge clk);
          if (data_ready === 1'b1) begin
            dr_count++;
            vectors++;
            if (prev_dr) begin
              miscompares++;
              $display("[TB] FAIL ready_width: data_ready high on consecutive cycles, required one");
            end
            if (sb.size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL unexpected_ready: h=%h t=%h, required no pulse",
                       humidity_bcd, temperature_bcd);
            end else begin
              e = sb.pop_front();
              vectors++;
              if (humidity_bcd !== e.h) begin
                miscompares++;
                $display("[TB] FAIL humidity: got %h required %h", humidity_bcd, e.h);
              end
              vectors++;
              if (temperature_bcd !== e.t) begin
                miscompares++;
                $display("[TB] FAIL temperature: got %h required %h", temperature_bcd, e.t);
              end
              vectors++;
              if (negativo_temp !== e.n) begin
                miscompares++;
                $display("[TB] FAIL sign: got %b required %b", negativo_temp, e.n);
              end
            end
          end
          prev_dr = data_ready;
        end
      end
    join_none

    test_reset();
    test_basic();
    test_negative();
    test_parity_error();
    test_no_response();
    test_back_to_back();
    test_reset_mid();
    repeat (20) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
